// File: rtl/demux_if.sv
// rtl/demux_if.sv - Producer and two-consumer handshake bundle for the buffered 1-to-2 demux.
interface demux_if #(
  parameter int BUS_WIDTH = 4,
  parameter int DEPTH     = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [BUS_WIDTH-1:0] d;
  logic                 d_valid;
  logic                 d_ready;
  logic                 switch;

  logic [BUS_WIDTH-1:0] a;
  logic                 a_valid;
  logic                 a_ready;
  logic [BUS_WIDTH-1:0] b;
  logic                 b_valid;
  logic                 b_ready;

  logic [CNT_W-1:0]     a_count;
  logic [CNT_W-1:0]     b_count;

  // master drives the producer side and both consumer readies
  modport master (
    output d, d_valid, switch, a_ready, b_ready,
    input  d_ready, a, a_valid, b, b_valid, a_count, b_count
  );

  modport slave (
    input  d, d_valid, switch, a_ready, b_ready,
    output d_ready, a, a_valid, b, b_valid, a_count, b_count
  );
endinterface

// File: rtl/demux.sv
// rtl/demux.sv - Buffered 1-to-2 demultiplexer with one small FIFO per output.
module demux #(
  parameter int BUS_WIDTH = 4,
  parameter int DEPTH     = 2
) (
  input logic    clk,
  input logic    rst_n,
  demux_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [1:0]           full;
  logic [1:0]           push;
  logic [1:0]           pop;
  logic [1:0]           out_ready;
  logic [CNT_W-1:0]     cnt  [2];
  logic [BUS_WIDTH-1:0] head [2];

  // No pass-through: a full FIFO refuses input even if it pops this cycle.
  assign bus.d_ready = bus.switch ? !full[1] : !full[0];

  assign push[0]   = bus.d_valid && bus.d_ready && !bus.switch;
  assign push[1]   = bus.d_valid && bus.d_ready &&  bus.switch;
  assign out_ready = {bus.b_ready, bus.a_ready};
  assign pop[0]    = (cnt[0] != '0) && out_ready[0];
  assign pop[1]    = (cnt[1] != '0) && out_ready[1];

  for (genvar ch = 0; ch < 2; ch++) begin : g_fifo
    logic [BUS_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push[ch]) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop[ch])  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push[ch] && !pop[ch])      count_d = count_q + CNT_W'(1);
      else if (!push[ch] && pop[ch]) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    // Storage needs no reset: reads are zero-gated by the count.
    always_ff @(posedge clk) begin
      if (push[ch]) mem_q[wr_ptr_q] <= bus.d;
    end

    assign full[ch] = (count_q == CNT_W'(DEPTH));
    assign cnt[ch]  = count_q;
    assign head[ch] = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  end

  assign bus.a       = head[0];
  assign bus.a_valid = (cnt[0] != '0);
  assign bus.a_count = cnt[0];
  assign bus.b       = head[1];
  assign bus.b_valid = (cnt[1] != '0);
  assign bus.b_count = cnt[1];
endmodule
